spi_rx_ip: RTL and testbench
============================

// Module: spi_rx_ip
// PURPOSE
//  SPI mode-0 receiver (slave end) for the display link. Oversamples cs/scl/sda/dc
//  from an external SPI master on the system clock and assembles MSB-first bytes.
//  Stores each byte with its dc tag in a small FIFO that the processor drains via rd_en.
//  Sits beside the SPI transmitter IP as its loopback/peripheral-side counterpart.
// PARAMETERS
//  FIFO_AW      2   FIFO address width; depth = 2**FIFO_AW entries (default 4)
//  SYNC_STAGES  2   input synchronizer flops per SPI line (>=2)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  enable       in   1  1: receive; 0: ignore bus, hold bit counter at 0
//  cs_in        in   1  SPI chip select, active-low
//  scl_in       in   1  SPI clock from master (period >= 8 clk)
//  sda_in       in   1  SPI data (MOSI)
//  dc_in        in   1  data/command line, 0: command, 1: data
//  rd_en        in   1  pop FIFO head; ignored when rx_empty
//  rx_data      out  8  FIFO head byte (valid while !rx_empty)
//  rx_dc        out  1  dc tag of FIFO head
//  rx_empty     out  1  FIFO empty
//  rx_full      out  1  FIFO full
//  rx_valid     out  1  1-cycle pulse: byte completed and written to FIFO
//  frame_abort  out  1  1-cycle pulse: cs rose with 1..7 bits pending
//  busy         out  1  cs asserted (synchronized) and enable=1
// BEHAVIOUR
//  - Reset: rx_data=0, rx_dc=0, rx_empty=1, rx_full=0, rx_valid=0, frame_abort=0,
//    busy=0; FIFO pointers, count, bit counter, shift reg, sync flops cleared
//    (cs sync flops reset to 1). Reset mid-byte discards partial byte and FIFO content.
//  - Inputs pass SYNC_STAGES flops, plus one history flop for edge detection
//    (scl_rise = sync=1 & hist=0; cs_rise likewise).
//  - States: IDLE (cs high or enable=0), SHIFT (cs low, counting bits).
//    IDLE->SHIFT when sync cs=0 and enable=1; SHIFT->IDLE on cs_rise or enable=0.
//  - SHIFT: on each scl_rise cycle, shift_reg <= {shift_reg[6:0], sda_sync}, bit_cnt+1.
//  - On the scl_rise of bit 8: next clk edge writes {dc_sync, byte} into FIFO,
//    pulses rx_valid that same cycle, bit_cnt wraps to 0; stays in SHIFT for next byte.
//    Latency: rx_valid/rx_empty=0 one clk after the 8th scl_rise is detected.
//  - dc is sampled on the 8th scl_rise; dc changes mid-byte are irrelevant.
//  - cs_rise with bit_cnt 1..7: partial byte dropped, frame_abort pulses 1 cycle,
//    bit_cnt=0. cs_rise with bit_cnt=0: no pulse. enable falling: same rules.
//  - FIFO: first-word-fall-through; rx_data/rx_dc reflect head combinationally
//    from storage; rd_en & !rx_empty advances read pointer next edge.
//  - Full + completed byte: byte dropped, FIFO unchanged, rx_valid not pulsed.
//  - Full + rd_en + completed byte same cycle: pop and push both occur, stays full.
//  - Empty + rd_en: no effect. Pointers wrap modulo depth; count is FIFO_AW+1 bits.
//  - scl edges while cs high are ignored; bit_cnt held at 0.
// CONFIGURATION
//  SPI_RX_OVERRUN_EN defined: adds port overrun (out,1) and clr_overrun (in,1).
//    overrun sets (sticky) when a completed byte is dropped on full; clears on
//    clr_overrun or reset; set wins over clear in the same cycle.
//  Not defined: ports absent; dropped bytes are silently discarded.
// TESTING
//  1 enable=1, cs low, send 0xA5 dc=0 -> rx_valid pulse, rx_data=A5, rx_dc=0, rx_empty=0.
//  2 send 0x3C dc=1 then 0x81 dc=0 in one cs frame; rd_en twice -> 3C/1, 81/0, rx_empty=1.
//  3 5 bits of 0xFF then cs high; new frame 0x5A -> frame_abort 1 pulse, FIFO holds only 5A.
//  4 send 5 bytes 01..05, no reads -> rx_full=1, FIFO 01..04; overrun=1 if SPI_RX_OVERRUN_EN.
//  5 FIFO full, rd_en on cycle 0x06 completes -> 02..04,06 stored, rx_full stays 1.
//  6 reset after 4 bits of 0xF0, then send 0x0F -> all outputs reset values, then rx_data=0F.

Source files
------------

// File: rtl/spi_rx_ip.sv
// SPI mode-0 slave receiver: oversampled cs/scl/sda/dc, MSB-first byte assembly, FWFT FIFO with dc tag.
// Optional sticky overrun flag with clr_overrun when SPI_RX_OVERRUN_EN is defined.
module spi_rx_ip #(
    parameter int FIFO_AW     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       cs_in,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       dc_in,
    input  logic       rd_en,
`ifdef SPI_RX_OVERRUN_EN
    input  logic       clr_overrun,
    output logic       overrun,
`endif
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       rx_valid,
    output logic       frame_abort,
    output logic       busy
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, scl_sync_q, sda_sync_q, dc_sync_q;
    logic                   scl_hist_q;
    logic                   cs_s, scl_s, sda_s, dc_s, scl_rise;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        wr_req, abort_d;
    logic        rx_valid_q, frame_abort_q;

    logic [8:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               push, pop, full, empty;

    // cs idles high so its synchronizer resets to 1, avoiding a false frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q  <= '1;
            scl_sync_q <= '0;
            sda_sync_q <= '0;
            dc_sync_q  <= '0;
            scl_hist_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_in};
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            dc_sync_q  <= {dc_sync_q[SYNC_STAGES-2:0], dc_in};
            scl_hist_q <= scl_s;
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign dc_s     = dc_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            rx_valid_q    <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_valid_q    <= push;
            frame_abort_q <= abort_d;
        end
    end

    // In SHIFT, cs high can only follow a detected cs rise, so testing the level covers it.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wr_req    = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                if (!cs_s && enable) state_d = SHIFT;
            end
            SHIFT: begin
                if (cs_s || !enable) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    abort_d   = (bit_cnt_q != 3'd0);
                end else if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    wr_req    = (bit_cnt_q == 3'd7);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = rd_en & ~empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    assign push  = wr_req & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 9'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {dc_s, shift_q[6:0], sda_s};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

`ifdef SPI_RX_OVERRUN_EN
    logic overrun_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   overrun_q <= 1'b0;
        else if (wr_req && !push)    overrun_q <= 1'b1;
        else if (clr_overrun)        overrun_q <= 1'b0;
    end
    assign overrun = overrun_q;
`endif

    assign rx_data     = mem_q[rd_ptr_q][7:0];
    assign rx_dc       = mem_q[rd_ptr_q][8];
    assign rx_empty    = empty;
    assign rx_full     = full;
    assign rx_valid    = rx_valid_q;
    assign frame_abort = frame_abort_q;
    assign busy        = ~cs_s & enable;

endmodule

// File: tb/tb_spi_rx_ip.sv
// Self-checking bench for spi_rx_ip: table-driven byte vectors plus hand-written frame/FIFO/reset sequences.
// Handshake: rd_en pops the head on the clock edge only when rx_empty is 0; rx_valid marks each stored byte.
module tb_spi_rx_ip;
    logic       clk = 1'b0;
    logic       reset, enable, cs_in, scl_in, sda_in, dc_in, rd_en;
    logic [7:0] rx_data;
    logic       rx_dc, rx_empty, rx_full, rx_valid, frame_abort, busy;
`ifdef SPI_RX_OVERRUN_EN
    logic       clr_overrun, overrun;
`endif

    spi_rx_ip #(.FIFO_AW(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cs_in(cs_in),
        .scl_in(scl_in), .sda_in(sda_in), .dc_in(dc_in), .rd_en(rd_en),
`ifdef SPI_RX_OVERRUN_EN
        .clr_overrun(clr_overrun), .overrun(overrun),
`endif
        .rx_data(rx_data), .rx_dc(rx_dc), .rx_empty(rx_empty), .rx_full(rx_full),
        .rx_valid(rx_valid), .frame_abort(frame_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int abort_cnt = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       dc;
    } vec_t;
    vec_t vecs[8];

    always @(negedge clk) begin
        if (rx_valid) valid_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // With two sync stages the rise is seen two edges after scl goes high; rd_en is lined up with that push edge.
    task automatic send_bit(input logic b, input logic pop_last);
        sda_in = b;
        scl_in = 1'b0;
        wait_neg(4);
        scl_in = 1'b1;
        if (pop_last) begin
            wait_neg(2);
            rd_en = 1'b1;
            wait_neg(1);
            rd_en = 1'b0;
            wait_neg(1);
        end else begin
            wait_neg(4);
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input logic dc, input int nbits, input logic pop_last);
        dc_in = dc;
        for (int i = 0; i < nbits; i++) send_bit(data[7-i], pop_last && (i == 7));
    endtask

    task automatic read_check(input string name);
        logic [8:0] e;
        check({name, "_not_empty"}, int'(rx_empty), 0);
        if (exp_q.size() == 0) begin
            check({name, "_queue_has_entry"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({name, "_data"}, int'(rx_data), int'(e[7:0]));
            check({name, "_dc"}, int'(rx_dc), int'(e[8]));
        end
        rd_en = 1'b1;
        wait_neg(1);
        rd_en = 1'b0;
    endtask

    task automatic frame_start();
        cs_in  = 1'b0;
        scl_in = 1'b0;
        wait_neg(4);
    endtask

    task automatic frame_end();
        cs_in  = 1'b1;
        scl_in = 1'b0;
        wait_neg(6);
    endtask

    int v0, a0;

    initial begin
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b1};
        vecs[2] = '{8'h81, 1'b0};
        vecs[3] = '{8'h00, 1'b1};
        vecs[4] = '{8'hFF, 1'b0};
        for (int i = 5; i < 8; i++) vecs[i] = '{8'($urandom_range(0, 255)), 1'($urandom_range(0, 1))};

        reset = 1'b1; enable = 1'b1; cs_in = 1'b1; scl_in = 1'b0;
        sda_in = 1'b0; dc_in = 1'b0; rd_en = 1'b0;
`ifdef SPI_RX_OVERRUN_EN
        clr_overrun = 1'b0;
`endif
        wait_neg(3);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_dc", int'(rx_dc), 0);
        check("rst_rx_empty", int'(rx_empty), 1);
        check("rst_rx_full", int'(rx_full), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_frame_abort", int'(frame_abort), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        wait_neg(2);

        // Pop on empty must be ignored.
        rd_en = 1'b1;
        wait_neg(1);
        rd_en = 1'b0;
        check("empty_pop_ignored", int'(rx_empty), 1);

        // Table: bytes in one frame, drained in pairs.
        frame_start();
        check("busy_in_frame", int'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            v0 = valid_cnt;
            send_byte(vecs[i].data, vecs[i].dc, 8, 1'b0);
            exp_q.push_back({vecs[i].dc, vecs[i].data});
            check($sformatf("vec%0d_valid_pulse", i), valid_cnt - v0, 1);
            if (i % 2 == 1) begin
                read_check($sformatf("vec%0d_a", i));
                read_check($sformatf("vec%0d_b", i));
                check($sformatf("vec%0d_drained", i), int'(rx_empty), 1);
            end
        end
        a0 = abort_cnt;
        frame_end();
        check("busy_after_frame", int'(busy), 0);
        check("clean_cs_rise_no_abort", abort_cnt - a0, 0);

        // Partial byte aborted by cs rise, next frame unaffected.
        frame_start();
        a0 = abort_cnt;
        send_byte(8'hFF, 1'b0, 5, 1'b0);
        frame_end();
        check("partial_abort_pulse", abort_cnt - a0, 1);
        check("partial_not_stored", int'(rx_empty), 1);
        frame_start();
        send_byte(8'h5A, 1'b1, 8, 1'b0);
        exp_q.push_back({1'b1, 8'h5A});
        frame_end();
        read_check("after_abort");
        check("after_abort_only_one", int'(rx_empty), 1);

        // Dropping enable mid-byte follows the same abort rule.
        frame_start();
        a0 = abort_cnt;
        send_byte(8'hE0, 1'b0, 3, 1'b0);
        enable = 1'b0;
        wait_neg(6);
        check("enable_drop_abort", abort_cnt - a0, 1);
        check("enable_drop_busy", int'(busy), 0);
        enable = 1'b1;
        wait_neg(4);
        send_byte(8'hC3, 1'b0, 8, 1'b0);
        exp_q.push_back({1'b0, 8'hC3});
        frame_end();
        read_check("after_enable");

        // Overfill: 5 bytes into a 4-deep FIFO.
        frame_start();
        v0 = valid_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b0, 8, 1'b0);
            if (i <= 4) exp_q.push_back({1'b0, 8'(i)});
        end
        check("overfill_valid_count", valid_cnt - v0, 4);
        check("overfill_full", int'(rx_full), 1);
`ifdef SPI_RX_OVERRUN_EN
        check("overrun_set", int'(overrun), 1);
`endif

        // Full with a pop on the completing edge: pop and push both happen.
        check("full_head_before_pop", int'(rx_data), int'(exp_q[0][7:0]));
        void'(exp_q.pop_front());
        v0 = valid_cnt;
        send_byte(8'h06, 1'b1, 8, 1'b1);
        exp_q.push_back({1'b1, 8'h06});
        check("full_pop_push_valid", valid_cnt - v0, 1);
        check("full_pop_push_stays_full", int'(rx_full), 1);
        frame_end();
`ifdef SPI_RX_OVERRUN_EN
        clr_overrun = 1'b1;
        wait_neg(1);
        clr_overrun = 1'b0;
        check("overrun_cleared", int'(overrun), 0);
`endif
        for (int i = 0; i < 4; i++) read_check($sformatf("drain%0d", i));
        check("drain_empty", int'(rx_empty), 1);
        check("drain_not_full", int'(rx_full), 0);

        // Reset mid-byte with a byte already stored.
        frame_start();
        send_byte(8'h77, 1'b1, 8, 1'b0);
        send_byte(8'hF0, 1'b0, 4, 1'b0);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_rx_data", int'(rx_data), 0);
        check("midrst_rx_dc", int'(rx_dc), 0);
        check("midrst_rx_empty", int'(rx_empty), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rx_valid", int'(rx_valid), 0);
        wait_neg(2);
        cs_in = 1'b1;
        reset = 1'b0;
        wait_neg(4);
        frame_start();
        v0 = valid_cnt;
        send_byte(8'h0F, 1'b1, 8, 1'b0);
        exp_q.push_back({1'b1, 8'h0F});
        check("post_rst_valid", valid_cnt - v0, 1);
        frame_end();
        read_check("post_rst");
        check("post_rst_empty", int'(rx_empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
